mem_stage: RTL and testbench

Memory-access stage of the five-stage pipeline, directly downstream of the execute stage. It consumes the execute-stage flow bundle (ALU result as address, rs2 data as store data, memory and write-back controls) and drives a variable-latency data-memory bus with a valid/ready request and a valid-only response. It aligns loads and stores by byte lane, stalls the upstream pipeline while a transaction is outstanding, and registers the MEM/WB flow bundle for the write-back stage.

---
 rtl/mem_stage_pkg.sv | 47 ++++
 rtl/mem_stage_if.sv | 21 ++
 rtl/mem_stage_align.sv | 50 +++++
 rtl/mem_stage.sv | 153 +++++++++++++++
 tb/tb_mem_stage.sv | 225 ++++++++++++++++++++++
 5 files changed

// File: rtl/mem_stage_pkg.sv
// Flow bundles shared by the EX/MEM and MEM/WB pipeline registers,
// plus the memory access width codes (funct3 encoding).
package pipeline_flow;

  localparam logic [2:0] MW_B  = 3'b000;
  localparam logic [2:0] MW_H  = 3'b001;
  localparam logic [2:0] MW_W  = 3'b010;
  localparam logic [2:0] MW_BU = 3'b100;
  localparam logic [2:0] MW_HU = 3'b101;

  typedef struct packed {
    logic       mem_read;
    logic       mem_write;
    logic [2:0] mem_width;
  } mem_ctrl_t;

  typedef struct packed {
    logic       reg_write;
    logic       mem_to_reg;
    logic [4:0] rd;
  } wb_ctrl_t;

  typedef struct packed {
    logic [31:0] alu_result;
    logic [31:0] rs2_data;
    logic [31:0] pc_incr;
    mem_ctrl_t   mem_ctrl;
    wb_ctrl_t    wb_ctrl;
  } ex_mem_flow_t;

  typedef struct packed {
    logic [31:0] alu_result;
    logic [31:0] load_data;
    logic [31:0] pc_incr;
    wb_ctrl_t    wb_ctrl;
  } mem_wb_flow_t;

  // Halfwords need an even address, words a 4-byte aligned one; bytes never trap.
  function automatic logic is_misaligned(input logic [2:0] width, input logic [1:0] lo);
    case (width[1:0])
      2'b01:   return lo[0];
      2'b10:   return lo != 2'b00;
      default: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/mem_stage_if.sv
// Data-memory bus: valid/ready request channel, valid-only response channel.
interface mem_stage_if;
  logic        dmem_req;
  logic        dmem_we;
  logic [31:0] dmem_addr;
  logic [31:0] dmem_wdata;
  logic [3:0]  dmem_be;
  logic        dmem_ready;
  logic        dmem_rvalid;
  logic [31:0] dmem_rdata;

  modport master (
    output dmem_req, dmem_we, dmem_addr, dmem_wdata, dmem_be,
    input  dmem_ready, dmem_rvalid, dmem_rdata
  );

  modport slave (
    input  dmem_req, dmem_we, dmem_addr, dmem_wdata, dmem_be,
    output dmem_ready, dmem_rvalid, dmem_rdata
  );
endinterface

// File: rtl/mem_stage_align.sv
// Byte-lane alignment: store lane replication / byte enables and
// load lane extraction with sign or zero extension.
module mem_align
  import pipeline_flow::*;
(
  input  logic [1:0]  addr_lo,
  input  logic [2:0]  width,
  input  logic [31:0] data,
  input  logic [31:0] rdata,
  output logic [3:0]  be,
  output logic [31:0] wdata,
  output logic [31:0] load_data
);

  logic [31:0] shifted;

  // Store path: replicate the datum across lanes, enable only the addressed bytes.
  always_comb begin
    be    = 4'b1111;
    wdata = data;
    case (width[1:0])
      2'b00: begin
        be    = 4'b0001 << addr_lo;
        wdata = {4{data[7:0]}};
      end
      2'b01: begin
        be    = 4'b0011 << addr_lo;
        wdata = {2{data[15:0]}};
      end
      default: begin
        be    = 4'b1111;
        wdata = data;
      end
    endcase
  end

  // Load path: bring the addressed lane down to bit 0, then extend.
  always_comb begin
    shifted   = rdata >> {addr_lo, 3'b000};
    load_data = rdata;
    case (width)
      MW_B:    load_data = 32'($signed(shifted[7:0]));
      MW_H:    load_data = 32'($signed(shifted[15:0]));
      MW_BU:   load_data = {24'd0, shifted[7:0]};
      MW_HU:   load_data = {16'd0, shifted[15:0]};
      default: load_data = rdata;
    endcase
  end

endmodule

// File: rtl/mem_stage.sv
// Memory-access stage: issues one data-memory transaction per memory
// instruction, stalls upstream while it is outstanding, and registers
// the MEM/WB bundle. Misaligned accesses and bus timeouts complete
// with an exception flag and the register write suppressed.
module mem_stage
  import pipeline_flow::*;
#(
  parameter int BUS_TIMEOUT = 255
) (
  input  logic         clk,
  input  logic         rst_n,
  input  ex_mem_flow_t inflow,
  input  logic         in_valid,
  output mem_wb_flow_t outflow,
  output logic         out_valid,
  output logic         stall,
  mem_stage_if.master  bus,
  output logic         exc_misalign,
  output logic         exc_bus
);

  localparam logic [31:0] TO_LIMIT = 32'(BUS_TIMEOUT);

  typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_t;

  state_t      state;
  logic [31:0] addr_q;
  logic [31:0] pc_q;
  logic [2:0]  width_q;
  wb_ctrl_t    wb_q;
  logic [31:0] ld_q;
  logic        mis_q;
  logic        bus_q;
  logic [31:0] cnt;

  logic        mem_op;
  logic        misalign;
  logic        timeout;
  logic [31:0] cnt_next;
  logic [1:0]  al_lo;
  logic [2:0]  al_width;
  logic [3:0]  al_be;
  logic [31:0] al_wdata;
  logic [31:0] al_load;

  assign mem_op   = inflow.mem_ctrl.mem_read | inflow.mem_ctrl.mem_write;
  assign misalign = is_misaligned(inflow.mem_ctrl.mem_width, inflow.alu_result[1:0]);
  assign cnt_next = cnt + 32'd1;
  assign timeout  = (TO_LIMIT != 32'd0) && (cnt_next == TO_LIMIT);

  // The aligner sees the incoming instruction in IDLE and the latched one afterwards.
  assign al_lo    = (state == IDLE) ? inflow.alu_result[1:0]    : addr_q[1:0];
  assign al_width = (state == IDLE) ? inflow.mem_ctrl.mem_width : width_q;

  assign bus.dmem_req = (state == REQ);
  assign stall = ((state == IDLE) && in_valid && mem_op) || (state == REQ) || (state == WAIT);

  mem_align u_align (
    .addr_lo   (al_lo),
    .width     (al_width),
    .data      (inflow.rs2_data),
    .rdata     (bus.dmem_rdata),
    .be        (al_be),
    .wdata     (al_wdata),
    .load_data (al_load)
  );

  // Transaction FSM, latched request fields and the MEM/WB register (p0 -> p1 boundary).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= IDLE;
      outflow        <= '0;
      out_valid      <= 1'b0;
      exc_misalign   <= 1'b0;
      exc_bus        <= 1'b0;
      bus.dmem_we    <= 1'b0;
      bus.dmem_addr  <= '0;
      bus.dmem_wdata <= '0;
      bus.dmem_be    <= 4'b0000;
      addr_q         <= '0;
      pc_q           <= '0;
      width_q        <= '0;
      wb_q           <= '0;
      ld_q           <= '0;
      mis_q          <= 1'b0;
      bus_q          <= 1'b0;
      cnt            <= '0;
    end else begin
      out_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (in_valid && !mem_op) begin
            outflow      <= '{alu_result: inflow.alu_result, load_data: 32'd0,
                              pc_incr: inflow.pc_incr, wb_ctrl: inflow.wb_ctrl};
            out_valid    <= 1'b1;
            exc_misalign <= 1'b0;
            exc_bus      <= 1'b0;
          end else if (in_valid) begin
            addr_q  <= inflow.alu_result;
            pc_q    <= inflow.pc_incr;
            width_q <= inflow.mem_ctrl.mem_width;
            wb_q    <= inflow.wb_ctrl;
            ld_q    <= '0;
            bus_q   <= 1'b0;
            cnt     <= '0;
            if (misalign) begin
              mis_q             <= 1'b1;
              wb_q.reg_write    <= 1'b0;
              state             <= DONE;
            end else begin
              mis_q          <= 1'b0;
              bus.dmem_we    <= inflow.mem_ctrl.mem_write;
              bus.dmem_addr  <= {inflow.alu_result[31:2], 2'b00};
              bus.dmem_wdata <= al_wdata;
              bus.dmem_be    <= al_be;
              state          <= REQ;
            end
          end
        end
        REQ: begin
          cnt <= cnt_next;
          if (bus.dmem_ready) begin
            state <= bus.dmem_we ? DONE : WAIT;
          end else if (timeout) begin
            bus_q          <= 1'b1;
            wb_q.reg_write <= 1'b0;
            state          <= DONE;
          end
        end
        WAIT: begin
          cnt <= cnt_next;
          if (bus.dmem_rvalid) begin
            ld_q  <= al_load;
            state <= DONE;
          end else if (timeout) begin
            bus_q          <= 1'b1;
            wb_q.reg_write <= 1'b0;
            state          <= DONE;
          end
        end
        DONE: begin
          outflow      <= '{alu_result: addr_q, load_data: ld_q, pc_incr: pc_q, wb_ctrl: wb_q};
          out_valid    <= 1'b1;
          exc_misalign <= mis_q;
          exc_bus      <= bus_q;
          state        <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage: one instance with the default bus timeout
// and one with BUS_TIMEOUT = 4 for the timeout case.
module tb_mem_stage;
  import pipeline_flow::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  ex_mem_flow_t inflow, inflow_t;
  logic         in_valid, in_valid_t;
  mem_wb_flow_t outflow, outflow_t;
  logic         out_valid, out_valid_t, stall, stall_t;
  logic         exc_misalign, exc_misalign_t, exc_bus, exc_bus_t;

  mem_stage_if bus ();
  mem_stage_if bus_t ();

  mem_stage dut (
    .clk(clk), .rst_n(rst_n), .inflow(inflow), .in_valid(in_valid),
    .outflow(outflow), .out_valid(out_valid), .stall(stall), .bus(bus),
    .exc_misalign(exc_misalign), .exc_bus(exc_bus)
  );

  mem_stage #(.BUS_TIMEOUT(4)) dut_to (
    .clk(clk), .rst_n(rst_n), .inflow(inflow_t), .in_valid(in_valid_t),
    .outflow(outflow_t), .out_valid(out_valid_t), .stall(stall_t), .bus(bus_t),
    .exc_misalign(exc_misalign_t), .exc_bus(exc_bus_t)
  );

  int tests = 0;
  int fails = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
    end
  endtask

  function automatic ex_mem_flow_t mk(input logic [31:0] alu, input logic [31:0] rs2,
                                      input logic rd, input logic wr, input logic [2:0] w);
    ex_mem_flow_t f;
    f = '0;
    f.alu_result = alu;
    f.rs2_data   = rs2;
    f.pc_incr    = 32'h0000_1004;
    f.mem_ctrl   = '{mem_read: rd, mem_write: wr, mem_width: w};
    f.wb_ctrl    = '{reg_write: 1'b1, mem_to_reg: rd, rd: 5'd7};
    return f;
  endfunction

  // Results of the last issue() call
  int           lat, nstall, nreq;
  logic         stable;
  logic         r_we;
  logic [31:0]  r_addr, r_wdata;
  logic [3:0]   r_be;
  mem_wb_flow_t r_out;
  logic         r_mis, r_bus;

  // Presents one instruction, holds it while stall is high, plays the memory
  // side (ready after rdy_dly REQ cycles, rvalid the cycle after), and records
  // latency (cycles from presentation to out_valid), stall and request cycles.
  task automatic issue(input bit to, input ex_mem_flow_t f, input int rdy_dly, input logic [31:0] rdata);
    bit prev_stall;
    logic v_req, v_we, v_stall, v_ov;
    logic [31:0] v_addr, v_wdata;
    logic [3:0] v_be;
    prev_stall = 1'b0;
    lat = -1; nstall = 0; nreq = 0; stable = 1'b1;
    for (int k = 0; k < 16 && lat < 0; k++) begin
      @(posedge clk); #1;
      if (k == 0) begin
        if (to) begin inflow_t = f; in_valid_t = 1'b1; end
        else begin inflow = f; in_valid = 1'b1; end
      end else if (!prev_stall) begin
        in_valid = 1'b0; in_valid_t = 1'b0;
      end
      if (!to) begin
        bus.dmem_ready  = (k == 1 + rdy_dly);
        bus.dmem_rvalid = (k == 2 + rdy_dly);
        bus.dmem_rdata  = rdata;
      end
      @(negedge clk);
      v_req   = to ? bus_t.dmem_req   : bus.dmem_req;
      v_we    = to ? bus_t.dmem_we    : bus.dmem_we;
      v_addr  = to ? bus_t.dmem_addr  : bus.dmem_addr;
      v_wdata = to ? bus_t.dmem_wdata : bus.dmem_wdata;
      v_be    = to ? bus_t.dmem_be    : bus.dmem_be;
      v_stall = to ? stall_t : stall;
      v_ov    = to ? out_valid_t : out_valid;
      if (v_req) begin
        if (nreq == 0) begin
          r_we = v_we; r_addr = v_addr; r_wdata = v_wdata; r_be = v_be;
        end else if (v_we !== r_we || v_addr !== r_addr || v_wdata !== r_wdata || v_be !== r_be) begin
          stable = 1'b0;
        end
        nreq++;
      end
      if (v_stall) nstall++;
      prev_stall = v_stall;
      if (v_ov) begin
        lat   = k;
        r_out = to ? outflow_t : outflow;
        r_mis = to ? exc_misalign_t : exc_misalign;
        r_bus = to ? exc_bus_t : exc_bus;
      end
    end
    bus.dmem_ready = 1'b0; bus.dmem_rvalid = 1'b0;
    in_valid = 1'b0; in_valid_t = 1'b0;
  endtask

  task automatic load_case(input string tag, input logic [31:0] a, input logic [2:0] w,
                           input logic [31:0] rdata, input logic [31:0] exp);
    issue(1'b0, mk(a, 32'd0, 1'b1, 1'b0, w), 0, rdata);
    check({tag, "_lat"}, 32'(lat), 32'd4);
    check({tag, "_stall"}, 32'(nstall), 32'd3);
    check({tag, "_data"}, r_out.load_data, exp);
    check({tag, "_regw"}, 32'(r_out.wb_ctrl.reg_write), 32'd1);
  endtask

  task automatic store_case(input string tag, input logic [31:0] a, input logic [2:0] w,
                            input logic [31:0] rs2, input int dly,
                            input logic [3:0] be, input logic [31:0] wd);
    issue(1'b0, mk(a, rs2, 1'b0, 1'b1, w), dly, 32'd0);
    check({tag, "_lat"}, 32'(lat), 32'(3 + dly));
    check({tag, "_stall"}, 32'(nstall), 32'(2 + dly));
    check({tag, "_nreq"}, 32'(nreq), 32'(1 + dly));
    check({tag, "_stable"}, 32'(stable), 32'd1);
    check({tag, "_we"}, 32'(r_we), 32'd1);
    check({tag, "_addr"}, r_addr, {a[31:2], 2'b00});
    check({tag, "_be"}, 32'(r_be), 32'(be));
    check({tag, "_wdata"}, r_wdata, wd);
  endtask

  int ov_seen;

  initial begin
    inflow = '0; inflow_t = '0; in_valid = 1'b0; in_valid_t = 1'b0;
    bus.dmem_ready = 1'b0; bus.dmem_rvalid = 1'b0; bus.dmem_rdata = '0;
    bus_t.dmem_ready = 1'b0; bus_t.dmem_rvalid = 1'b0; bus_t.dmem_rdata = '0;

    // Reset state
    repeat (2) @(negedge clk);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_stall", 32'(stall), 32'd0);
    check("rst_req", 32'(bus.dmem_req), 32'd0);
    check("rst_we", 32'(bus.dmem_we), 32'd0);
    check("rst_addr", bus.dmem_addr, 32'd0);
    check("rst_wdata", bus.dmem_wdata, 32'd0);
    check("rst_be", 32'(bus.dmem_be), 32'd0);
    check("rst_out_alu", outflow.alu_result, 32'd0);
    check("rst_exc", 32'({exc_misalign, exc_bus}), 32'd0);
    @(posedge clk); #1 rst_n = 1'b1;

    // Non-memory instruction
    issue(1'b0, mk(32'h0000_1234, 32'd0, 1'b0, 1'b0, MW_W), 0, 32'd0);
    check("nonmem_lat", 32'(lat), 32'd1);
    check("nonmem_stall", 32'(nstall), 32'd0);
    check("nonmem_nreq", 32'(nreq), 32'd0);
    check("nonmem_alu", r_out.alu_result, 32'h0000_1234);
    check("nonmem_ld", r_out.load_data, 32'd0);
    @(negedge clk);
    check("nonmem_ov_drop", 32'(out_valid), 32'd0);

    // Loads
    load_case("lb", 32'h0000_0103, MW_B, 32'h80FF_FFFF, 32'hFFFF_FF80);
    check("lb_addr", r_addr, 32'h0000_0100);
    check("lb_we", 32'(r_we), 32'd0);
    load_case("lbu", 32'h0000_0103, MW_BU, 32'h80FF_FFFF, 32'h0000_0080);
    load_case("lh", 32'h0000_0102, MW_H, 32'h8001_1234, 32'hFFFF_8001);
    load_case("lhu", 32'h0000_0102, MW_HU, 32'h8001_1234, 32'h0000_8001);
    load_case("lw", 32'h0000_0104, MW_W, 32'hDEAD_BEEF, 32'hDEAD_BEEF);

    // Stores
    store_case("sh", 32'h0000_0102, MW_H, 32'hABCD_1234, 3, 4'b1100, 32'h1234_1234);
    store_case("sb", 32'h0000_0101, MW_B, 32'h0000_0077, 0, 4'b0010, 32'h7777_7777);
    store_case("sw", 32'h0000_0200, MW_W, 32'hCAFE_F00D, 0, 4'b1111, 32'hCAFE_F00D);

    // Misaligned word load
    issue(1'b0, mk(32'h0000_0101, 32'd0, 1'b1, 1'b0, MW_W), 0, 32'd0);
    check("mis_lat", 32'(lat), 32'd2);
    check("mis_stall", 32'(nstall), 32'd1);
    check("mis_nreq", 32'(nreq), 32'd0);
    check("mis_exc", 32'(r_mis), 32'd1);
    check("mis_regw", 32'(r_out.wb_ctrl.reg_write), 32'd0);

    // Bus timeout on the BUS_TIMEOUT = 4 instance, ready never asserted
    issue(1'b1, mk(32'h0000_0100, 32'd0, 1'b1, 1'b0, MW_W), 0, 32'd0);
    check("to_lat", 32'(lat), 32'd6);
    check("to_nreq", 32'(nreq), 32'd4);
    check("to_exc_bus", 32'(r_bus), 32'd1);
    check("to_regw", 32'(r_out.wb_ctrl.reg_write), 32'd0);
    @(negedge clk);
    check("to_req_drop", 32'(bus_t.dmem_req), 32'd0);

    // Reset while a load waits for its response
    @(posedge clk); #1;
    inflow = mk(32'h0000_0100, 32'd0, 1'b1, 1'b0, MW_W); in_valid = 1'b1;
    @(posedge clk); #1 bus.dmem_ready = 1'b1;
    @(posedge clk); #1 bus.dmem_ready = 1'b0;
    check("wr_in_wait", 32'(stall), 32'd1);
    rst_n = 1'b0; in_valid = 1'b0;
    #1;
    check("wr_req", 32'(bus.dmem_req), 32'd0);
    check("wr_stall", 32'(stall), 32'd0);
    check("wr_be", 32'(bus.dmem_be), 32'd0);
    check("wr_addr", bus.dmem_addr, 32'd0);
    @(posedge clk); #1 rst_n = 1'b1;
    @(posedge clk); #1 bus.dmem_rvalid = 1'b1; bus.dmem_rdata = 32'h5555_AAAA;
    @(posedge clk); #1 bus.dmem_rvalid = 1'b0;
    ov_seen = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (out_valid) ov_seen++;
    end
    check("wr_late_rvalid", 32'(ov_seen), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
